decode_general_register_stage: RTL and testbench

//  Registered, handshaked successor of the combinational general-register decoder.

---
 rtl/decode_general_register_stage_pkg.sv | 57 +++++
 rtl/decode_general_register_stage_if.sv | 44 ++++
 rtl/decode_general_register_stage_scoreboard.sv | 24 ++
 rtl/decode_general_register_stage.sv | 112 +++++++++++
 tb/tb_decode_general_register_stage.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/decode_general_register_stage_pkg.sv
// Shared types, lane-mask constants and operand decode helpers for the
// registered general-register decode stage.
package decode_general_register_pkg;

   typedef enum logic [2:0] {
      EAX = 3'd0,
      ECX = 3'd1,
      EDX = 3'd2,
      EBX = 3'd3,
      ESP = 3'd4,
      EBP = 3'd5,
      ESI = 3'd6,
      EDI = 3'd7
   } gpr_e;

   localparam int GPR_COUNT = 8;
   localparam int LANES     = 4;
   localparam int SB_W      = GPR_COUNT * LANES;

   localparam logic [3:0] LANE_L8 = 4'b0001;
   localparam logic [3:0] LANE_H8 = 4'b0010;
   localparam logic [3:0] LANE_16 = 4'b0011;
   localparam logic [3:0] LANE_32 = 4'b1111;

   typedef struct packed {
      logic [7:0] sel;
      logic [3:0] byte_en;
   } dec_t;

   // Codes 4-7 name the high byte of EAX..EBX when the operand is 8-bit.
   function automatic dec_t decode_operand(input logic [2:0] code,
                                           input logic       eff_w,
                                           input logic [1:0] bit_width);
      dec_t d;
      d = '0;
      if (!eff_w) begin
         d.sel[{1'b0, code[1:0]}] = 1'b1;
         d.byte_en                = code[2] ? LANE_H8 : LANE_L8;
      end else begin
         d.sel[code] = 1'b1;
         d.byte_en   = bit_width[1] ? LANE_32 : LANE_16;
      end
      return d;
   endfunction

   // Expands a GPR select and lane mask into the flat 8x4 scoreboard layout.
   function automatic logic [SB_W-1:0] lane_mask(input logic [7:0] sel,
                                                 input logic [3:0] byte_en);
      logic [SB_W-1:0] m;
      m = '0;
      for (int g = 0; g < GPR_COUNT; g++) begin
         if (sel[g]) m[g*LANES +: LANES] = byte_en;
      end
      return m;
   endfunction

endpackage

// File: rtl/decode_general_register_stage_if.sv
// Handshake, operand and write-back bundle for the decode stage.
// master = upstream/driver side, slave = the decode stage itself.
interface decode_general_register_stage_if #(
   parameter int NUM_SRC = 2,
   parameter int NUM_DST = 1,
   parameter int NUM_WB  = 1
);
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [1:0]             in_bit_width;
   logic                   in_w_in_instruction;
   logic                   in_w;
   logic [NUM_SRC-1:0]     in_src_en;
   logic [NUM_SRC*3-1:0]   in_src_code;
   logic [NUM_DST-1:0]     in_dst_en;
   logic [NUM_DST*3-1:0]   in_dst_code;
   logic                   out_valid;
   logic                   out_ready;
   logic [NUM_SRC*8-1:0]   out_src_sel;
   logic [NUM_SRC*4-1:0]   out_src_byte_en;
   logic [NUM_DST*8-1:0]   out_dst_sel;
   logic [NUM_DST*4-1:0]   out_dst_byte_en;
   logic [NUM_WB-1:0]      wb_valid;
   logic [NUM_WB*8-1:0]    wb_sel;
   logic [NUM_WB*4-1:0]    wb_byte_en;
   logic                   hazard;

   modport master (
      output flush, in_valid, in_bit_width, in_w_in_instruction, in_w,
             in_src_en, in_src_code, in_dst_en, in_dst_code, out_ready,
             wb_valid, wb_sel, wb_byte_en,
      input  in_ready, out_valid, out_src_sel, out_src_byte_en,
             out_dst_sel, out_dst_byte_en, hazard
   );

   modport slave (
      input  flush, in_valid, in_bit_width, in_w_in_instruction, in_w,
             in_src_en, in_src_code, in_dst_en, in_dst_code, out_ready,
             wb_valid, wb_sel, wb_byte_en,
      output in_ready, out_valid, out_src_sel, out_src_byte_en,
             out_dst_sel, out_dst_byte_en, hazard
   );
endinterface

// File: rtl/decode_general_register_stage_scoreboard.sv
// In-flight destination lane tracker: 8 GPRs x 4 byte lanes.
// o_sb_eff already has this cycle's write-back lanes removed so a retiring
// register does not stall the instruction that reads it.
module decode_general_register_scoreboard
   import decode_general_register_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            i_flush,
   input  logic [SB_W-1:0] i_set,
   input  logic [SB_W-1:0] i_clr,
   output logic [SB_W-1:0] o_sb_eff
);
   logic [SB_W-1:0] r_sb;

   assign o_sb_eff = r_sb & ~i_clr;

   // Update lane state; set is applied after clear so a new issue beats a retire.
   always_ff @(posedge clock) begin
      if (reset)        r_sb <= '0;
      else if (i_flush) r_sb <= '0;
      else              r_sb <= (r_sb & ~i_clr) | i_set;
   end
endmodule

// File: rtl/decode_general_register_stage.sv
// Registered general-register decode stage: decodes operand codes into GPR
// selects and byte-lane masks, stalls on scoreboard overlap, and presents the
// result through a single valid/ready output register.
module decode_general_register_stage
   import decode_general_register_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int NUM_DST = 1,
   parameter int NUM_WB  = 1
) (
   input  logic                          clock,
   input  logic                          reset,
   decode_general_register_stage_if.slave bus
);
   logic                 w_eff_w;
   logic [NUM_SRC*8-1:0] w_src_sel;
   logic [NUM_SRC*4-1:0] w_src_be;
   logic [NUM_DST*8-1:0] w_dst_sel;
   logic [NUM_DST*4-1:0] w_dst_be;
   logic [SB_W-1:0]      w_src_masks [NUM_SRC];
   logic [SB_W-1:0]      w_dst_masks [NUM_DST];
   logic [SB_W-1:0]      w_src_mask;
   logic [SB_W-1:0]      w_dst_mask;
   logic [SB_W-1:0]      w_wb_clr;
   logic [SB_W-1:0]      w_sb_eff;
   logic [SB_W-1:0]      w_sb_set;
   logic                 w_accept;

   logic                 r_out_valid;
   logic [NUM_SRC*8-1:0] r_src_sel;
   logic [NUM_SRC*4-1:0] r_src_be;
   logic [NUM_DST*8-1:0] r_dst_sel;
   logic [NUM_DST*4-1:0] r_dst_be;

   // Opcodes without a w bit always address the full operand size.
   assign w_eff_w = bus.in_w | ~bus.in_w_in_instruction;

   for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      dec_t w_dec;
      assign w_dec = bus.in_src_en[gi]
                   ? decode_operand(bus.in_src_code[gi*3 +: 3], w_eff_w, bus.in_bit_width)
                   : '0;
      assign w_src_sel[gi*8 +: 8] = w_dec.sel;
      assign w_src_be[gi*4 +: 4]  = w_dec.byte_en;
      assign w_src_masks[gi]      = lane_mask(w_dec.sel, w_dec.byte_en);
   end

   for (genvar gi = 0; gi < NUM_DST; gi++) begin : g_dst
      dec_t w_dec;
      assign w_dec = bus.in_dst_en[gi]
                   ? decode_operand(bus.in_dst_code[gi*3 +: 3], w_eff_w, bus.in_bit_width)
                   : '0;
      assign w_dst_sel[gi*8 +: 8] = w_dec.sel;
      assign w_dst_be[gi*4 +: 4]  = w_dec.byte_en;
      assign w_dst_masks[gi]      = lane_mask(w_dec.sel, w_dec.byte_en);
   end

   // Combine per-port lane masks and the retiring write-back lanes.
   always_comb begin
      w_src_mask = '0;
      w_dst_mask = '0;
      w_wb_clr   = '0;
      for (int i = 0; i < NUM_SRC; i++) w_src_mask |= w_src_masks[i];
      for (int i = 0; i < NUM_DST; i++) w_dst_mask |= w_dst_masks[i];
      for (int i = 0; i < NUM_WB; i++) begin
         if (bus.wb_valid[i])
            w_wb_clr |= lane_mask(bus.wb_sel[i*8 +: 8], bus.wb_byte_en[i*4 +: 4]);
      end
   end

   // Only in-flight state counts; src/dst overlap within one instruction is fine.
   assign bus.hazard   = bus.in_valid & (|((w_src_mask | w_dst_mask) & w_sb_eff));
   assign bus.in_ready = ~bus.hazard & (~r_out_valid | bus.out_ready) & ~bus.flush;
   assign w_accept     = bus.in_valid & bus.in_ready;
   assign w_sb_set     = w_accept ? w_dst_mask : '0;

   decode_general_register_scoreboard u_sb (
      .clock    (clock),
      .reset    (reset),
      .i_flush  (bus.flush),
      .i_set    (w_sb_set),
      .i_clr    (w_wb_clr),
      .o_sb_eff (w_sb_eff)
   );

   // Output register: load on accept, drain on consume, drop on flush.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_src_sel   <= '0;
         r_src_be    <= '0;
         r_dst_sel   <= '0;
         r_dst_be    <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_src_sel   <= w_src_sel;
         r_src_be    <= w_src_be;
         r_dst_sel   <= w_dst_sel;
         r_dst_be    <= w_dst_be;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.out_valid       = r_out_valid;
   assign bus.out_src_sel     = r_src_sel;
   assign bus.out_src_byte_en = r_src_be;
   assign bus.out_dst_sel     = r_dst_sel;
   assign bus.out_dst_byte_en = r_dst_be;
endmodule

// File: tb/tb_decode_general_register_stage.sv
// Directed bench for decode_general_register_stage: a decode vector table
// plus hand-written hazard, stall, flush and reset sequences.
module tb_decode_general_register_stage;
   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clock = ~clock;

   decode_general_register_stage_if #(.NUM_SRC(2), .NUM_DST(1), .NUM_WB(1)) bus ();

   decode_general_register_stage #(.NUM_SRC(2), .NUM_DST(1), .NUM_WB(1)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        w_in;
      logic        w;
      logic [1:0]  bw;
      logic [1:0]  src_en;
      logic [5:0]  src_code;
      logic        dst_en;
      logic [2:0]  dst_code;
      logic [15:0] exp_src_sel;
      logic [7:0]  exp_src_be;
      logic [7:0]  exp_dst_sel;
      logic [3:0]  exp_dst_be;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_op(input logic w_in, input logic w, input logic [1:0] bw,
                         input logic [1:0] src_en, input logic [5:0] src_code,
                         input logic dst_en, input logic [2:0] dst_code);
      bus.in_w_in_instruction = w_in;
      bus.in_w                = w;
      bus.in_bit_width        = bw;
      bus.in_src_en           = src_en;
      bus.in_src_code         = src_code;
      bus.in_dst_en           = dst_en;
      bus.in_dst_code         = dst_code;
      bus.in_valid            = 1'b1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_src_en = '0;
      bus.in_dst_en = '0;
      bus.wb_valid  = '0;
      bus.wb_sel    = '0;
      bus.wb_byte_en = '0;
   endtask

   task automatic do_flush();
      idle();
      bus.flush = 1'b1;
      @(negedge clock);
      bus.flush = 1'b0;
   endtask

   initial begin
      //          w_in w    bw     src_en src_code            dst dcode  src_sel   src_be dst_sel dst_be
      vecs[0] = '{1'b1,1'b0,2'b10, 2'b01, {3'd0,3'd4}, 1'b0, 3'd0, 16'h0001, 8'h02, 8'h00, 4'h0};
      vecs[1] = '{1'b0,1'b0,2'b01, 2'b01, {3'd0,3'd3}, 1'b0, 3'd0, 16'h0008, 8'h03, 8'h00, 4'h0};
      vecs[2] = '{1'b1,1'b1,2'b11, 2'b11, {3'd2,3'd7}, 1'b1, 3'd5, 16'h0480, 8'hFF, 8'h20, 4'hF};
      vecs[3] = '{1'b1,1'b0,2'b00, 2'b11, {3'd6,3'd1}, 1'b1, 3'd0, 16'h0402, 8'h21, 8'h01, 4'h1};
      vecs[4] = '{1'b1,1'b1,2'b00, 2'b01, {3'd0,3'd5}, 1'b1, 3'd4, 16'h0020, 8'h03, 8'h10, 4'h3};
      vecs[5] = '{1'b1,1'b1,2'b10, 2'b10, {3'd3,3'd0}, 1'b0, 3'd0, 16'h0800, 8'hF0, 8'h00, 4'h0};
      vecs[6] = '{1'b1,1'b1,2'b10, 2'b00, {3'd3,3'd3}, 1'b0, 3'd3, 16'h0000, 8'h00, 8'h00, 4'h0};

      reset = 1'b1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      bus.in_bit_width = 2'b00;
      bus.in_w_in_instruction = 1'b0;
      bus.in_w = 1'b0;
      bus.in_src_code = '0;
      bus.in_dst_code = '0;
      idle();
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset_in_ready",  {31'b0, bus.in_ready},  32'd1);
      chk("reset_hazard",    {31'b0, bus.hazard},    32'd0);
      chk("reset_sel_be", {bus.out_src_sel, bus.out_src_byte_en, bus.out_dst_sel}, 32'd0);
      reset = 1'b0;

      // Decode table: one accept per vector, scoreboard cleared between them.
      for (int i = 0; i < 7; i++) begin
         @(negedge clock);
         set_op(vecs[i].w_in, vecs[i].w, vecs[i].bw, vecs[i].src_en,
                vecs[i].src_code, vecs[i].dst_en, vecs[i].dst_code);
         #1;
         chk($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, 32'd1);
         @(negedge clock);
         idle();
         #1;
         chk($sformatf("vec%0d_out_valid", i), {31'b0, bus.out_valid}, 32'd1);
         chk($sformatf("vec%0d_src_sel", i), {16'b0, bus.out_src_sel}, {16'b0, vecs[i].exp_src_sel});
         chk($sformatf("vec%0d_src_be", i), {24'b0, bus.out_src_byte_en}, {24'b0, vecs[i].exp_src_be});
         chk($sformatf("vec%0d_dst", i), {20'b0, bus.out_dst_sel, bus.out_dst_byte_en},
             {20'b0, vecs[i].exp_dst_sel, vecs[i].exp_dst_be});
         do_flush();
      end

      // RAW on EAX, released by same-cycle write-back.
      set_op(1'b1, 1'b1, 2'b10, 2'b00, 6'd0, 1'b1, 3'd0);
      @(negedge clock);
      set_op(1'b1, 1'b0, 2'b10, 2'b01, 6'd0, 1'b0, 3'd0);
      #1;
      chk("raw_hazard",   {31'b0, bus.hazard},   32'd1);
      chk("raw_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(negedge clock);
      bus.wb_valid = 1'b1; bus.wb_sel = 8'h01; bus.wb_byte_en = 4'hF;
      #1;
      chk("wb_bypass_hazard",   {31'b0, bus.hazard},   32'd0);
      chk("wb_bypass_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clock);
      idle();
      #1;
      chk("wb_bypass_out", {bus.out_valid, 15'b0, bus.out_src_sel[7:0], 4'b0, bus.out_src_byte_en[3:0]},
          {1'b1, 15'b0, 8'h01, 4'b0, 4'h1});
      do_flush();

      // Issue and retire of the same lanes in one cycle: the issue survives.
      set_op(1'b1, 1'b1, 2'b10, 2'b00, 6'd0, 1'b1, 3'd0);
      bus.wb_valid = 1'b1; bus.wb_sel = 8'h01; bus.wb_byte_en = 4'hF;
      @(negedge clock);
      idle();
      set_op(1'b1, 1'b1, 2'b10, 2'b01, 6'd0, 1'b0, 3'd0);
      #1;
      chk("set_wins_hazard", {31'b0, bus.hazard}, 32'd1);
      bus.wb_valid = 1'b1; bus.wb_sel = 8'h80; bus.wb_byte_en = 4'hF;
      #1;
      chk("wb_clear_bit_hazard", {31'b0, bus.hazard}, 32'd1);
      @(negedge clock);
      do_flush();

      // Disjoint lanes: AH in flight does not block AL.
      set_op(1'b1, 1'b0, 2'b10, 2'b00, 6'd0, 1'b1, 3'd4);
      @(negedge clock);
      set_op(1'b1, 1'b0, 2'b10, 2'b01, 6'd0, 1'b0, 3'd0);
      #1;
      chk("disjoint_hazard",   {31'b0, bus.hazard},   32'd0);
      chk("disjoint_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clock);
      idle();
      #1;
      chk("disjoint_out", {bus.out_valid, 15'b0, bus.out_src_sel[7:0], 4'b0, bus.out_src_byte_en[3:0]},
          {1'b1, 15'b0, 8'h01, 4'b0, 4'h1});
      do_flush();

      // Backpressure hold, then flush with ECX still in flight.
      bus.out_ready = 1'b0;
      set_op(1'b1, 1'b1, 2'b01, 2'b00, 6'd0, 1'b1, 3'd1);
      @(negedge clock);
      set_op(1'b1, 1'b1, 2'b01, 2'b01, 6'd2, 1'b0, 3'd0);
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("stall%0d_in_ready", c), {31'b0, bus.in_ready}, 32'd0);
         chk($sformatf("stall%0d_out", c), {bus.out_valid, 19'b0, bus.out_dst_sel, bus.out_dst_byte_en},
             {1'b1, 19'b0, 8'h02, 4'h3});
         @(negedge clock);
      end
      bus.flush = 1'b1;
      #1;
      chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd0);
      @(negedge clock);
      bus.flush = 1'b0;
      idle();
      #1;
      chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
      bus.out_ready = 1'b1;
      set_op(1'b1, 1'b1, 2'b01, 2'b01, 6'd1, 1'b0, 3'd0);
      #1;
      chk("post_flush_hazard",   {31'b0, bus.hazard},   32'd0);
      chk("post_flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clock);
      idle();
      #1;
      chk("post_flush_out", {bus.out_valid, 15'b0, bus.out_src_sel[7:0], 4'b0, bus.out_src_byte_en[3:0]},
          {1'b1, 15'b0, 8'h02, 4'b0, 4'h3});

      // Reset taken mid-stall together with flush.
      bus.out_ready = 1'b0;
      set_op(1'b1, 1'b1, 2'b10, 2'b00, 6'd0, 1'b1, 3'd3);
      @(negedge clock);
      idle();
      reset = 1'b1;
      bus.flush = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      bus.flush = 1'b0;
      set_op(1'b1, 1'b1, 2'b10, 2'b01, 6'd3, 1'b0, 3'd0);
      #1;
      chk("reset_stall_out_valid", {31'b0, bus.out_valid}, 32'd0);
      chk("reset_stall_hazard",    {31'b0, bus.hazard},    32'd0);
      chk("reset_stall_dst_sel",   {24'b0, bus.out_dst_sel}, 32'd0);
      @(negedge clock);
      idle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
